fifo_rd_stream: RTL and testbench

Read-side adapter for the synchronous FIFO. It issues `Rd_Req` pops against the FIFO's `Empty` flag and captures the FIFO's registered `Data_out` one cycle after each pop. It presents the words in order on a valid/ready stream toward the consumer. A 3-entry internal buffer absorbs the pop-to-data latency, so throughput is one word per cycle with no combinational path from `Out_Ready` to `Rd_Req`.

---
 rtl/fifo_rd_stream_pkg.sv | 16 +
 rtl/fifo_rd_stream_if.sv | 29 ++
 rtl/fifo_rd_stream_rd_skid_buf.sv | 53 +++++
 rtl/fifo_rd_stream.sv | 50 +++++
 tb/tb_fifo_rd_stream.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/fifo_rd_stream_pkg.sv
// Shared constants for the FIFO read-side adapter: buffer depth, pointer width
// and the default data width that must match the FIFO being drained.
package fifo_rd_stream_pkg;

  localparam int RD_BUF_DEPTH   = 3;
  localparam int RD_PTR_W       = 2;
  localparam int FIFO_WIDTH_DEF = 8;

  typedef logic [RD_PTR_W-1:0] rd_ptr_t;

  // Depth is not a power of two, so wrap explicitly at the last slot.
  function automatic rd_ptr_t rd_ptr_inc(input rd_ptr_t p);
    return (p == rd_ptr_t'(RD_BUF_DEPTH - 1)) ? '0 : rd_ptr_t'(p + 2'd1);
  endfunction

endpackage

// File: rtl/fifo_rd_stream_if.sv
// Bundle between the read adapter, the FIFO it drains and the downstream consumer.
interface fifo_rd_stream_if #(
  parameter int FIFO_WIDTH = fifo_rd_stream_pkg::FIFO_WIDTH_DEF
);

  // FIFO side: a pop happens on every clock edge where Rd_Req is 1; the FIFO's
  // registered Data_out carries that word during the following cycle.
  // Stream side: a word transfers on every edge where Out_Valid && Out_Ready;
  // Out_Valid never depends on Out_Ready.
  logic                  Fifo_Empty;
  logic [FIFO_WIDTH-1:0] Fifo_Data;
  logic                  Rd_Req;
  logic                  Flush;
  logic [FIFO_WIDTH-1:0] Out_Data;
  logic                  Out_Valid;
  logic                  Out_Ready;
  logic [1:0]            Out_Level;

  modport master (
    input  Fifo_Empty, Fifo_Data, Flush, Out_Ready,
    output Rd_Req, Out_Data, Out_Valid, Out_Level
  );

  modport slave (
    output Fifo_Empty, Fifo_Data, Flush, Out_Ready,
    input  Rd_Req, Out_Data, Out_Valid, Out_Level
  );

endinterface

// File: rtl/fifo_rd_stream_rd_skid_buf.sv
// Three-entry circular store that absorbs the FIFO pop-to-data latency.
module rd_skid_buf
  import fifo_rd_stream_pkg::*;
#(
  parameter int W = FIFO_WIDTH_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  input  logic         flush,
  output logic [W-1:0] head_data,
  output rd_ptr_t      count
);

  logic [W-1:0] mem [RD_BUF_DEPTH];
  rd_ptr_t      wr_ptr;
  rd_ptr_t      rd_ptr;
  logic         pop_ok;

  assign pop_ok    = pop && (count != '0);
  assign head_data = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RD_BUF_DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= rd_ptr_inc(wr_ptr);
      end
      if (pop_ok) rd_ptr <= rd_ptr_inc(rd_ptr);
      case ({push, pop_ok})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // The parent's credit check keeps count + in-flight within the depth.
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && !flush && !pop_ok && (count == rd_ptr_t'(RD_BUF_DEPTH))));

endmodule

// File: rtl/fifo_rd_stream.sv
// FIFO read-side adapter: pops against Empty, captures registered data one cycle
// later and streams the words out in order on a valid/ready interface.
module fifo_rd_stream
  import fifo_rd_stream_pkg::*;
#(
  parameter int FIFO_WIDTH = FIFO_WIDTH_DEF
) (
  input  logic                 CLK,
  input  logic                 rst_n,
  fifo_rd_stream_if.master     bus
);

  logic            inflight;
  logic            rd_req;
  logic            capture;
  logic            transfer;
  logic [2:0]      credit_used;
  rd_ptr_t         count;
  logic [FIFO_WIDTH-1:0] head_data;

  // Credit counts words already buffered plus the one on its way, so Out_Ready
  // never reaches Rd_Req combinationally.
  assign credit_used = {1'b0, count} + {2'b00, inflight};
  assign rd_req      = rst_n && !bus.Fifo_Empty && !bus.Flush &&
                       (credit_used < 3'(RD_BUF_DEPTH));
  assign capture     = inflight && !bus.Flush;
  assign transfer    = bus.Out_Valid && bus.Out_Ready;

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) inflight <= 1'b0;
    else        inflight <= rd_req;
  end

  rd_skid_buf #(.W(FIFO_WIDTH)) u_buf (
    .clk       (CLK),
    .rst_n     (rst_n),
    .push      (capture),
    .push_data (bus.Fifo_Data),
    .pop       (transfer),
    .flush     (bus.Flush),
    .head_data (head_data),
    .count     (count)
  );

  assign bus.Rd_Req    = rd_req;
  assign bus.Out_Data  = head_data;
  assign bus.Out_Valid = (count != '0);
  assign bus.Out_Level = count;

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Directed bench for fifo_rd_stream against a small registered-output FIFO model.
module tb_fifo_rd_stream;

  logic CLK;
  logic rst_n;
  int   n_vec;
  int   n_err;

  logic [7:0] fifo_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] fifo_data;
  logic       fifo_empty;

  fifo_rd_stream_if #(.FIFO_WIDTH(8)) bus ();

  fifo_rd_stream #(.FIFO_WIDTH(8)) dut (
    .CLK   (CLK),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // FIFO model: registered Data_out and registered Empty, reset with the adapter.
  always @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      fifo_q.delete();
      fifo_data  <= 8'h00;
      fifo_empty <= 1'b1;
    end else begin
      if (bus.Rd_Req && fifo_q.size() > 0) fifo_data <= fifo_q.pop_front();
      fifo_empty <= (fifo_q.size() == 0);
    end
  end

  assign bus.Fifo_Data  = fifo_data;
  assign bus.Fifo_Empty = fifo_empty;

  task automatic push_word(input logic [7:0] w);
    fifo_q.push_back(w);
  endtask

  task automatic test_reset;
    rst_n = 1'b0; bus.Flush = 1'b0; bus.Out_Ready = 1'b0;
    repeat (2) @(negedge CLK);
    #1;
    n_vec++; if (bus.Out_Valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %0b want 0", bus.Out_Valid); end
    n_vec++; if (bus.Out_Level !== 2'd0) begin n_err++; $display("FAIL reset_level got %0d want 0", bus.Out_Level); end
    n_vec++; if (bus.Rd_Req !== 1'b0) begin n_err++; $display("FAIL reset_rdreq got %0b want 0", bus.Rd_Req); end
    n_vec++; if (bus.Out_Data !== 8'h00) begin n_err++; $display("FAIL reset_data got %h want 00", bus.Out_Data); end
    @(negedge CLK); rst_n = 1'b1;
    @(negedge CLK); #1;
    n_vec++; if (bus.Out_Valid !== 1'b0) begin n_err++; $display("FAIL idle_valid got %0b want 0", bus.Out_Valid); end
  endtask

  task automatic test_basic;
    int first_req, first_xfer, nx, npulse;
    first_req = -1; first_xfer = -1; nx = 0; npulse = 0;
    exp_q = '{8'h11, 8'h22, 8'h33};
    bus.Out_Ready = 1'b1;
    push_word(8'h11); push_word(8'h22); push_word(8'h33);
    for (int i = 0; i < 12; i++) begin
      @(negedge CLK); #1;
      if (bus.Rd_Req) begin npulse++; if (first_req < 0) first_req = i; end
      if (bus.Out_Valid && bus.Out_Ready) begin
        n_vec++;
        if (exp_q.size() == 0) begin n_err++; $display("FAIL basic_extra got %h want none", bus.Out_Data); end
        else begin
          logic [7:0] e;
          e = exp_q.pop_front();
          if (bus.Out_Data !== e) begin n_err++; $display("FAIL basic_data got %h want %h", bus.Out_Data, e); end
        end
        if (nx == 0) first_xfer = i;
        else begin
          n_vec++; if (i != first_xfer + nx) begin n_err++; $display("FAIL basic_gap got cycle %0d want %0d", i, first_xfer + nx); end
        end
        nx++;
      end
    end
    n_vec++; if (first_xfer - first_req != 2) begin n_err++; $display("FAIL basic_latency got %0d want 2", first_xfer - first_req); end
    n_vec++; if (nx != 3) begin n_err++; $display("FAIL basic_count got %0d want 3", nx); end
    n_vec++; if (npulse != 3) begin n_err++; $display("FAIL basic_pulses got %0d want 3", npulse); end
    n_vec++; if (bus.Out_Valid !== 1'b0) begin n_err++; $display("FAIL basic_drain got %0b want 0", bus.Out_Valid); end
  endtask

  task automatic test_backpressure;
    int npulse, nx, first_xfer;
    npulse = 0; nx = 0; first_xfer = -1;
    exp_q.delete();
    bus.Out_Ready = 1'b0;
    for (int k = 0; k < 8; k++) begin
      push_word(8'h40 + 8'(k));
      exp_q.push_back(8'h40 + 8'(k));
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK); #1;
      if (bus.Rd_Req) npulse++;
    end
    n_vec++; if (npulse != 3) begin n_err++; $display("FAIL bp_pulses got %0d want 3", npulse); end
    n_vec++; if (bus.Out_Level !== 2'd3) begin n_err++; $display("FAIL bp_level got %0d want 3", bus.Out_Level); end
    n_vec++; if (bus.Out_Data !== 8'h40) begin n_err++; $display("FAIL bp_head got %h want 40", bus.Out_Data); end
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK); bus.Out_Ready = 1'b1; #1;
      if (bus.Out_Valid) begin
        n_vec++;
        if (exp_q.size() == 0) begin n_err++; $display("FAIL bp_extra got %h want none", bus.Out_Data); end
        else begin
          logic [7:0] e;
          e = exp_q.pop_front();
          if (bus.Out_Data !== e) begin n_err++; $display("FAIL bp_data got %h want %h", bus.Out_Data, e); end
        end
        if (nx == 0) first_xfer = i;
        else if (i != first_xfer + nx) begin n_err++; $display("FAIL bp_gap got cycle %0d want %0d", i, first_xfer + nx); end
        nx++;
      end
    end
    n_vec++; if (nx != 8) begin n_err++; $display("FAIL bp_count got %0d want 8", nx); end
    n_vec++; if (bus.Out_Level !== 2'd0) begin n_err++; $display("FAIL bp_level_end got %0d want 0", bus.Out_Level); end
  endtask

  task automatic test_empty_boundary;
    int npulse, nx;
    npulse = 0; nx = 0;
    bus.Out_Ready = 1'b1;
    push_word(8'hA5);
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK); #1;
      if (bus.Rd_Req) npulse++;
      if (bus.Out_Valid && bus.Out_Ready) begin
        nx++;
        n_vec++; if (bus.Out_Data !== 8'hA5) begin n_err++; $display("FAIL empty_data got %h want a5", bus.Out_Data); end
      end
    end
    n_vec++; if (npulse != 1) begin n_err++; $display("FAIL empty_pulses got %0d want 1", npulse); end
    n_vec++; if (nx != 1) begin n_err++; $display("FAIL empty_xfers got %0d want 1", nx); end
    n_vec++; if (bus.Out_Valid !== 1'b0) begin n_err++; $display("FAIL empty_valid got %0b want 0", bus.Out_Valid); end
  endtask

  task automatic test_flush;
    logic found;
    int   nx;
    found = 1'b0; nx = 0;
    bus.Out_Ready = 1'b0;
    for (int k = 0; k < 5; k++) push_word(8'h61 + 8'(k));
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge CLK); #1;
      if (bus.Out_Level == 2'd2) found = 1'b1;
    end
    n_vec++; if (found !== 1'b1) begin n_err++; $display("FAIL flush_setup got level %0d want 2", bus.Out_Level); end
    bus.Flush = 1'b1; bus.Out_Ready = 1'b1; #1;
    n_vec++; if (bus.Out_Data !== 8'h61) begin n_err++; $display("FAIL flush_head got %h want 61", bus.Out_Data); end
    n_vec++; if (bus.Rd_Req !== 1'b0) begin n_err++; $display("FAIL flush_rdreq got %0b want 0", bus.Rd_Req); end
    @(negedge CLK); bus.Flush = 1'b0; #1;
    n_vec++; if (bus.Out_Valid !== 1'b0) begin n_err++; $display("FAIL flush_valid got %0b want 0", bus.Out_Valid); end
    n_vec++; if (bus.Out_Level !== 2'd0) begin n_err++; $display("FAIL flush_level got %0d want 0", bus.Out_Level); end
    exp_q = '{8'h64, 8'h65};
    for (int i = 0; i < 10; i++) begin
      if (i > 0) begin @(negedge CLK); #1; end
      if (bus.Out_Valid && bus.Out_Ready) begin
        nx++;
        n_vec++;
        if (exp_q.size() == 0) begin n_err++; $display("FAIL flush_extra got %h want none", bus.Out_Data); end
        else begin
          logic [7:0] e;
          e = exp_q.pop_front();
          if (bus.Out_Data !== e) begin n_err++; $display("FAIL flush_data got %h want %h", bus.Out_Data, e); end
        end
      end
    end
    n_vec++; if (nx != 2) begin n_err++; $display("FAIL flush_count got %0d want 2", nx); end
  endtask

  task automatic test_wrap;
    int   nx;
    logic bad_ptr, rd_wrap, wr_wrap;
    logic [1:0] prev_rd, prev_wr;
    nx = 0; bad_ptr = 1'b0; rd_wrap = 1'b0; wr_wrap = 1'b0;
    prev_rd = dut.u_buf.rd_ptr; prev_wr = dut.u_buf.wr_ptr;
    exp_q.delete();
    for (int k = 0; k < 10; k++) begin
      push_word(8'h80 + 8'(k));
      exp_q.push_back(8'h80 + 8'(k));
    end
    for (int i = 0; i < 80; i++) begin
      @(negedge CLK); bus.Out_Ready = (i % 3 == 0); #1;
      if (dut.u_buf.rd_ptr > 2'd2 || dut.u_buf.wr_ptr > 2'd2) bad_ptr = 1'b1;
      if (prev_rd == 2'd2 && dut.u_buf.rd_ptr == 2'd0) rd_wrap = 1'b1;
      if (prev_wr == 2'd2 && dut.u_buf.wr_ptr == 2'd0) wr_wrap = 1'b1;
      prev_rd = dut.u_buf.rd_ptr; prev_wr = dut.u_buf.wr_ptr;
      if (bus.Out_Valid && bus.Out_Ready) begin
        nx++;
        n_vec++;
        if (exp_q.size() == 0) begin n_err++; $display("FAIL wrap_extra got %h want none", bus.Out_Data); end
        else begin
          logic [7:0] e;
          e = exp_q.pop_front();
          if (bus.Out_Data !== e) begin n_err++; $display("FAIL wrap_data got %h want %h", bus.Out_Data, e); end
        end
      end
    end
    n_vec++; if (nx != 10) begin n_err++; $display("FAIL wrap_count got %0d want 10", nx); end
    n_vec++; if (bad_ptr !== 1'b0) begin n_err++; $display("FAIL wrap_ptr_range got %0b want 0", bad_ptr); end
    n_vec++; if ({rd_wrap, wr_wrap} !== 2'b11) begin n_err++; $display("FAIL wrap_seen got %b want 11", {rd_wrap, wr_wrap}); end
  endtask

  task automatic test_reset_mid;
    logic found;
    int   nx;
    found = 1'b0; nx = 0;
    bus.Out_Ready = 1'b0;
    for (int k = 0; k < 5; k++) push_word(8'hB0 + 8'(k));
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge CLK); #1;
      if (bus.Out_Level == 2'd2) found = 1'b1;
    end
    n_vec++; if (found !== 1'b1) begin n_err++; $display("FAIL rst_setup got level %0d want 2", bus.Out_Level); end
    rst_n = 1'b0; #1;
    for (int i = 0; i < 2; i++) begin
      n_vec++; if (bus.Out_Valid !== 1'b0) begin n_err++; $display("FAIL rst_valid got %0b want 0", bus.Out_Valid); end
      n_vec++; if (bus.Out_Level !== 2'd0) begin n_err++; $display("FAIL rst_level got %0d want 0", bus.Out_Level); end
      n_vec++; if (bus.Rd_Req !== 1'b0) begin n_err++; $display("FAIL rst_rdreq got %0b want 0", bus.Rd_Req); end
      @(negedge CLK); #1;
    end
    rst_n = 1'b1;
    bus.Out_Ready = 1'b1;
    exp_q = '{8'hC3, 8'h3C};
    push_word(8'hC3); push_word(8'h3C);
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK); #1;
      if (bus.Out_Valid && bus.Out_Ready) begin
        nx++;
        n_vec++;
        if (exp_q.size() == 0) begin n_err++; $display("FAIL rst_extra got %h want none", bus.Out_Data); end
        else begin
          logic [7:0] e;
          e = exp_q.pop_front();
          if (bus.Out_Data !== e) begin n_err++; $display("FAIL rst_data got %h want %h", bus.Out_Data, e); end
        end
      end
    end
    n_vec++; if (nx != 2) begin n_err++; $display("FAIL rst_count got %0d want 2", nx); end
  endtask

  initial begin
    n_vec = 0; n_err = 0;
    test_reset();
    test_basic();
    test_backpressure();
    test_empty_boundary();
    test_flush();
    test_wrap();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got running want finished");
    $fatal(1);
  end

endmodule
